// File: rtl/pll_reset_seq_pkg.sv
// pll_pkg: state encoding and counter sizing shared by the PLL reset sequencer.
package pll_pkg;
    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        RELEASE   = 2'd1,
        RUN       = 2'd2,
        HOLD      = 2'd3
    } state_t;

    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/pll_reset_seq_sync.sv
// sync_ff2: two-flop synchroniser with async active-high reset to 0.
module sync_ff2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/pll_reset_seq.sv
// pll_reset_seq: qualifies PLL lock, releases reset domains in staggered order,
// and re-asserts them on lock loss or software request.
module pll_reset_seq
    import pll_pkg::*;
#(
    parameter int NUM_RESETS  = 3,
    parameter int LOCK_CYCLES = 1024,
    parameter int STAGGER     = 16,
    parameter int HOLD_CYCLES = 64,
    parameter int CNT_W       = 8
) (
    input  logic                  clock_in,
    input  logic                  reset,
    input  logic                  locked,
    input  logic                  soft_reset_req,
    output logic [NUM_RESETS-1:0] rst_out,
    output logic                  ready,
    output logic [CNT_W-1:0]      lock_loss_count
);
    localparam int SPAN = (NUM_RESETS - 1) * STAGGER;
    localparam int MAX1 = (LOCK_CYCLES > HOLD_CYCLES) ? LOCK_CYCLES : HOLD_CYCLES;
    localparam int CW   = cnt_width((MAX1 > SPAN) ? MAX1 : SPAN);
    localparam state_t GO = (NUM_RESETS == 1) ? RUN : RELEASE;
    localparam logic [NUM_RESETS-1:0] FIRST = {NUM_RESETS{1'b1}} << 1;

    logic                  locked_s, lost;
    state_t                state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [NUM_RESETS-1:0] rst_next;
    logic [CNT_W-1:0]      count_next;
    int                    step;

    sync_ff2 u_sync (.clk(clock_in), .rst(reset), .d(locked), .q(locked_s));

    // One shared counter: lock filter, stagger and hold; cleared on every state change.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt + 1'b1;
        rst_next   = rst_out;
        step       = int'(cnt) + 1;
        lost       = !locked_s && state != WAIT_LOCK;
        count_next = (lost && !(&lock_loss_count)) ? lock_loss_count + 1'b1 : lock_loss_count;
        if (lost) begin
            state_n  = WAIT_LOCK;
            cnt_n    = '0;
            rst_next = '1;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (!locked_s) cnt_n = '0;
                    else if (cnt == CW'(LOCK_CYCLES - 1)) begin
                        state_n  = GO;
                        cnt_n    = '0;
                        rst_next = FIRST;
                    end
                end
                RELEASE: begin
                    for (int i = 1; i < NUM_RESETS; i++)
                        if (i * STAGGER <= step) rst_next[i] = 1'b0;
                    if (step == SPAN) begin
                        state_n = RUN;
                        cnt_n   = '0;
                    end
                end
                RUN: begin
                    cnt_n = '0;
                    if (soft_reset_req) begin
                        state_n  = HOLD;
                        rst_next = '1;
                    end
                end
                HOLD: begin
                    if (cnt == CW'(HOLD_CYCLES - 1)) begin
                        state_n  = GO;
                        cnt_n    = '0;
                        rst_next = FIRST;
                    end
                end
                default: begin
                    state_n  = WAIT_LOCK;
                    cnt_n    = '0;
                    rst_next = '1;
                end
            endcase
        end
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state           <= WAIT_LOCK;
            cnt             <= '0;
            rst_out         <= '1;
            ready           <= 1'b0;
            lock_loss_count <= '0;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            rst_out         <= rst_next;
            ready           <= state_n == RUN;
            lock_loss_count <= count_next;
        end
    end
endmodule
